// File: rtl/register_pkg.sv
// register_pkg: function-select encodings shared by the register, ALU and control unit.
package register_pkg;
  typedef logic [1:0] funsel_t;
  localparam funsel_t FS_CLEAR = 2'b00;
  localparam funsel_t FS_LOAD  = 2'b01;
  localparam funsel_t FS_DEC   = 2'b10;
  localparam funsel_t FS_INC   = 2'b11;
endpackage

// File: rtl/register.sv
// register: N-bit storage element with enable-gated clear/load/decrement/increment.
module register
  import register_pkg::*;
#(
  parameter int NBits = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       funsel,
  input  logic [NBits-1:0] i,
  input  logic             e,
  output logic [NBits-1:0] q
);
  localparam logic [NBits-1:0] ONE = NBits'(1);
  logic [NBits-1:0] r_q;
  if (NBits < 1) begin : g_bad_nbits
    $error("register: NBits must be at least 1");
  end
  // X/Z on funsel falls through to default and holds, so q is never corrupted
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_q <= '0;
    else if (e) begin
      case (funsel)
        FS_CLEAR: r_q <= '0;
        FS_LOAD:  r_q <= i;
        FS_DEC:   r_q <= r_q - ONE;
        FS_INC:   r_q <= r_q + ONE;
        default:  r_q <= r_q;
      endcase
    end
  end
  assign q = r_q;
  a_e_known: assert property (@(posedge clk) disable iff (rst) !$isunknown(e))
    else $error("register: enable is X/Z");
  a_funsel_known: assert property (@(posedge clk) disable iff (rst) e |-> !$isunknown(funsel))
    else $error("register: funsel is X/Z while enabled");
endmodule

// File: tb/tb_register.sv
// tb_register: randomized and directed checks of 8-bit and 4-bit registers against an arithmetic model.
module tb_register;
  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] fs8, fs4;
  logic [7:0] i8, q8;
  logic [3:0] i4, q4;
  logic       e8, e4;
  int         m8, m4;
  int         n_checks = 0;
  int         n_fail = 0;
  always #5 clk = ~clk;
  register #(.NBits(8)) dut8 (.clk(clk), .rst(rst), .funsel(fs8), .i(i8), .e(e8), .q(q8));
  register #(.NBits(4)) dut4 (.clk(clk), .rst(rst), .funsel(fs4), .i(i4), .e(e4), .q(q4));
  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic int nxt(input int cur, input int f, input int d, input int modulus);
    if (f == 0) return 0;
    if (f == 1) return d;
    if (f == 2) return (cur + modulus - 1) % modulus;
    return (cur + 1) % modulus;
  endfunction
  task automatic step(input string tag, input logic [1:0] f8, input logic [7:0] d8, input logic v8,
                      input logic [1:0] f4, input logic [3:0] d4, input logic v4);
    fs8 = f8; i8 = d8; e8 = v8;
    fs4 = f4; i4 = d4; e4 = v4;
    @(posedge clk);
    #1;
    if (rst) begin
      m8 = 0;
      m4 = 0;
    end else begin
      if (v8) m8 = nxt(m8, int'(f8), int'(d8), 256);
      if (v4) m4 = nxt(m4, int'(f4), int'(d4), 16);
    end
    check({tag, "/q8"}, int'(q8), m8);
    check({tag, "/q4"}, int'(q4), m4);
  endtask
  task automatic step8(input string tag, input logic [1:0] f, input logic [7:0] d);
    step(tag, f, d, 1'b1, 2'b00, 4'h0, 1'b0);
  endtask
  task automatic step4(input string tag, input logic [1:0] f, input logic [3:0] d);
    step(tag, 2'b00, 8'h00, 1'b0, f, d, 1'b1);
  endtask
  initial begin
    rst = 1'b1;
    fs8 = 2'b00; i8 = 8'h00; e8 = 1'b0;
    fs4 = 2'b00; i4 = 4'h0;  e4 = 1'b0;
    m8 = 0; m4 = 0;
    repeat (2) @(posedge clk);
    #1;
    check("reset/q8", int'(q8), 0);
    check("reset/q4", int'(q4), 0);
    rst = 1'b0;
    step8("preload", 2'b01, 8'hA5);
    check("preload_val", int'(q8), 8'hA5);
    rst = 1'b1;
    #2;
    check("async_rst", int'(q8), 0);
    m8 = 0; m4 = 0;
    step8("rst_over_load", 2'b01, 8'h77);
    check("rst_held", int'(q8), 0);
    rst = 1'b0;
    step8("load_after_rst", 2'b01, 8'h77);
    check("load_77", int'(q8), 8'h77);
    step8("load_3c", 2'b01, 8'h3C);
    for (int k = 0; k < 5; k++) step("hold", 2'(k), 8'hFF, 1'b0, 2'(k), 4'hF, 1'b0);
    check("hold_3c", int'(q8), 8'h3C);
    step8("load_fe", 2'b01, 8'hFE);
    step8("inc1", 2'b11, 8'h00);
    check("inc_ff", int'(q8), 8'hFF);
    step8("inc2", 2'b11, 8'h00);
    check("inc_wrap", int'(q8), 8'h00);
    step8("inc3", 2'b11, 8'h00);
    check("inc_01", int'(q8), 8'h01);
    step8("load_01", 2'b01, 8'h01);
    step8("dec1", 2'b10, 8'h00);
    check("dec_00", int'(q8), 8'h00);
    step8("dec2", 2'b10, 8'h00);
    check("dec_wrap", int'(q8), 8'hFF);
    step8("dec3", 2'b10, 8'h00);
    check("dec_fe", int'(q8), 8'hFE);
    step4("n4_load", 2'b01, 4'b1011);
    check("n4_1011", int'(q4), 4'b1011);
    step4("n4_clear", 2'b00, 4'hF);
    check("n4_0000", int'(q4), 0);
    step4("n4_load_f", 2'b01, 4'hF);
    step4("n4_inc", 2'b11, 4'h0);
    check("n4_inc_wrap", int'(q4), 0);
    step4("n4_dec", 2'b10, 4'h0);
    check("n4_dec_wrap", int'(q4), 4'hF);
    for (int k = 0; k < 300; k++) begin
      rst = ($urandom_range(0, 19) == 0);
      step("rand", 2'($urandom), 8'($urandom), 1'($urandom), 2'($urandom), 4'($urandom), 1'($urandom));
      rst = 1'b0;
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
